pc_sequencer: RTL and testbench

Fetch-stage controller that owns the architectural fetch PC and sequences instruction-memory requests. It chooses the next PC from sequential (PC+4), redirect (branch/jump from execute) or trap vector, and enforces a valid/ready request handshake toward imem. It tags every request with an epoch bit so that decode can drop wrong-path responses. It sits between the execute-stage redirect logic and the imem/icache request port.

---
 rtl/pc_seq_pkg.sv | 31 +++
 rtl/pc_next_sel.sv | 28 ++
 rtl/pc_sequencer.sv | 137 +++++++++++++
 tb/tb_pc_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared constants, state encodings and request payload for the fetch PC sequencer.
package pc_seq_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ST_W = 2;
    localparam int unsigned SEL_W = 2;

    localparam logic [XLEN-1:0] PC_INC       = 32'd4;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_2000;
    localparam logic [XLEN-1:0] TRAP_VEC_DEF = 32'h0000_0100;

    localparam logic [ST_W-1:0] ST_BOOT   = 2'd0;
    localparam logic [ST_W-1:0] ST_FETCH  = 2'd1;
    localparam logic [ST_W-1:0] ST_HOLD   = 2'd2;
    localparam logic [ST_W-1:0] ST_HALTED = 2'd3;

    localparam logic [SEL_W-1:0] SEL_KEEP = 2'd0;
    localparam logic [SEL_W-1:0] SEL_SEQ  = 2'd1;
    localparam logic [SEL_W-1:0] SEL_TGT  = 2'd2;
    localparam logic [SEL_W-1:0] SEL_HELD = 2'd3;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic            epoch;
    } imem_req_t;

    function automatic logic is_aligned(input logic [XLEN-1:0] a);
        return a[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC mux (keep/seq/redirect/held) with redirect alignment check.
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter logic [XLEN-1:0] TRAP_VEC = TRAP_VEC_DEF
) (
    input  logic [SEL_W-1:0] sel,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic [XLEN-1:0]  held_pc,
    output logic [XLEN-1:0]  tgt_c,
    output logic [XLEN-1:0]  pc_next_c,
    output logic             misalign_c
);

    always_comb begin
        misalign_c = !is_aligned(redirect_pc);
        tgt_c      = misalign_c ? TRAP_VEC : redirect_pc;
        pc_next_c  = pc;
        case (sel)
            SEL_SEQ:  pc_next_c = pc + PC_INC;
            SEL_TGT:  pc_next_c = tgt_c;
            SEL_HELD: pc_next_c = held_pc;
            default:  pc_next_c = pc;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage controller: owns the fetch PC/epoch and drives the imem valid/ready request port.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [XLEN-1:0] TRAP_VEC = TRAP_VEC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            halt,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    output logic            imem_req_epoch,
    output logic            misalign_err,
    output logic [XLEN-1:0] bad_pc,
    output logic            halted
);

    logic [ST_W-1:0]  state_q, state_d;
    imem_req_t        req_q, req_d;
    logic [XLEN-1:0]  held_pc_q, held_pc_d;
    logic             pending_q, pending_d;
    logic             misalign_d;
    logic [XLEN-1:0]  bad_pc_d;
    logic             epoch_d;
    logic             redirect_seen;
    logic [SEL_W-1:0] sel;
    logic [XLEN-1:0]  tgt;
    logic [XLEN-1:0]  pc_next;
    logic             misaligned;
    logic             hs;
    logic             busy;

    assign imem_req_valid = ((state_q == ST_FETCH) && (!stall || pending_q)) ||
                            (state_q == ST_HOLD);
    assign hs             = imem_req_valid && imem_req_ready;
    // An offered but unaccepted request must keep its address, even before pending is set.
    assign busy           = imem_req_valid && !imem_req_ready;

    assign imem_req_addr  = req_q.addr;
    assign imem_req_epoch = req_q.epoch;

    pc_next_sel #(
        .TRAP_VEC (TRAP_VEC)
    ) u_next_sel (
        .sel         (sel),
        .pc          (req_q.addr),
        .redirect_pc (redirect_pc),
        .held_pc     (held_pc_q),
        .tgt_c       (tgt),
        .pc_next_c   (pc_next),
        .misalign_c  (misaligned)
    );

    // Next-state and register-update decisions.
    always_comb begin
        state_d       = state_q;
        sel           = SEL_KEEP;
        epoch_d       = req_q.epoch;
        held_pc_d     = held_pc_q;
        redirect_seen = 1'b0;
        pending_d     = pending_q;
        if (hs) begin
            pending_d = 1'b0;
        end else if (imem_req_valid) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (redirect_valid) begin
                    redirect_seen = 1'b1;
                    if (busy) begin
                        held_pc_d = tgt;
                        state_d   = ST_HOLD;
                    end else begin
                        sel     = SEL_TGT;
                        epoch_d = ~req_q.epoch;
                    end
                end else begin
                    if (hs) begin
                        sel = SEL_SEQ;
                    end
                    if (halt && !busy) begin
                        state_d = ST_HALTED;
                    end
                end
            end
            ST_HOLD: begin
                redirect_seen = redirect_valid;
                if (redirect_valid) begin
                    held_pc_d = tgt;
                end
                if (hs) begin
                    sel     = redirect_valid ? SEL_TGT : SEL_HELD;
                    epoch_d = ~req_q.epoch;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_HALTED;
            end
        endcase

        req_d      = '{addr: pc_next, epoch: epoch_d};
        misalign_d = redirect_seen && misaligned;
        bad_pc_d   = misalign_d ? redirect_pc : bad_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            req_q        <= '{addr: RESET_PC, epoch: 1'b0};
            held_pc_q    <= '0;
            pending_q    <= 1'b0;
            misalign_err <= 1'b0;
            bad_pc       <= '0;
            halted       <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            held_pc_q    <= held_pc_d;
            pending_q    <= pending_d;
            misalign_err <= misalign_d;
            bad_pc       <= bad_pc_d;
            halted       <= (state_d == ST_HALTED);
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven cycle vectors plus a request scoreboard for pc_sequencer.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_req_epoch;
    logic        misalign_err;
    logic [31:0] bad_pc;
    logic        halted;

    pc_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_req_epoch (imem_req_epoch),
        .misalign_err   (misalign_err),
        .bad_pc         (bad_pc),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        hlt;
        logic        v;
        logic [31:0] addr;
        logic        ep;
        logic        me;
        logic        hd;
        logic [31:0] bad;
    } vec_t;

    vec_t        vq[$];
    logic [32:0] sb[$];
    int          checks = 0;
    int          errors = 0;

    function automatic vec_t mk(logic s, logic r, logic rv, logic [31:0] rpc, logic h,
                                logic v, logic [31:0] a, logic e, logic m, logic hd,
                                logic [31:0] b);
        vec_t t;
        t.stall = s; t.rdy = r; t.rv = rv; t.rpc = rpc; t.hlt = h;
        t.v = v; t.addr = a; t.ep = e; t.me = m; t.hd = hd; t.bad = b;
        return t;
    endfunction

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"},  33'(imem_req_valid), 33'(1'b0));
        chk({tag, "_addr"},   33'(imem_req_addr),  33'(32'h0000_2000));
        chk({tag, "_epoch"},  33'(imem_req_epoch), 33'(1'b0));
        chk({tag, "_mis"},    33'(misalign_err),   33'(1'b0));
        chk({tag, "_badpc"},  33'(bad_pc),         33'(32'h0));
        chk({tag, "_halted"}, 33'(halted),         33'(1'b0));
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; imem_req_ready = 1'b0;

        //          st rdy rv rpc            h   v  addr          ep me hd bad
        vq.push_back(mk(0, 1, 0, 32'h0,        0,  0, 32'h0000_2000, 0, 0, 0, 32'h0));
        vq.push_back(mk(0, 1, 0, 32'h0,        0,  1, 32'h0000_2000, 0, 0, 0, 32'h0));
        vq.push_back(mk(0, 1, 0, 32'h0,        0,  1, 32'h0000_2004, 0, 0, 0, 32'h0));
        vq.push_back(mk(0, 1, 0, 32'h0,        0,  1, 32'h0000_2008, 0, 0, 0, 32'h0));
        vq.push_back(mk(0, 1, 0, 32'h0,        0,  1, 32'h0000_200C, 0, 0, 0, 32'h0));
        vq.push_back(mk(0, 0, 0, 32'h0,        0,  1, 32'h0000_2010, 0, 0, 0, 32'h0));
        vq.push_back(mk(1, 0, 0, 32'h0,        0,  1, 32'h0000_2010, 0, 0, 0, 32'h0));
        vq.push_back(mk(0, 0, 0, 32'h0,        0,  1, 32'h0000_2010, 0, 0, 0, 32'h0));
        vq.push_back(mk(1, 1, 0, 32'h0,        0,  1, 32'h0000_2010, 0, 0, 0, 32'h0));
        vq.push_back(mk(1, 1, 0, 32'h0,        0,  0, 32'h0000_2014, 0, 0, 0, 32'h0));
        vq.push_back(mk(0, 1, 0, 32'h0,        0,  1, 32'h0000_2014, 0, 0, 0, 32'h0));
        vq.push_back(mk(1, 1, 1, 32'h0000_3000, 0, 0, 32'h0000_2018, 0, 0, 0, 32'h0));
        vq.push_back(mk(0, 1, 0, 32'h0,        0,  1, 32'h0000_3000, 1, 0, 0, 32'h0));
        vq.push_back(mk(0, 1, 1, 32'h0000_5000, 0, 1, 32'h0000_3004, 1, 0, 0, 32'h0));
        vq.push_back(mk(0, 0, 0, 32'h0,        0,  1, 32'h0000_5000, 0, 0, 0, 32'h0));
        vq.push_back(mk(0, 0, 1, 32'h0000_3000, 0, 1, 32'h0000_5000, 0, 0, 0, 32'h0));
        vq.push_back(mk(0, 0, 0, 32'h0,        0,  1, 32'h0000_5000, 0, 0, 0, 32'h0));
        vq.push_back(mk(0, 0, 1, 32'h0000_4000, 0, 1, 32'h0000_5000, 0, 0, 0, 32'h0));
        vq.push_back(mk(0, 1, 0, 32'h0,        0,  1, 32'h0000_5000, 0, 0, 0, 32'h0));
        vq.push_back(mk(0, 1, 0, 32'h0,        0,  1, 32'h0000_4000, 1, 0, 0, 32'h0));
        vq.push_back(mk(0, 1, 1, 32'h0000_3002, 0, 1, 32'h0000_4004, 1, 0, 0, 32'h0));
        vq.push_back(mk(0, 1, 0, 32'h0,        0,  1, 32'h0000_0100, 0, 1, 0, 32'h3002));
        vq.push_back(mk(1, 1, 0, 32'h0,        0,  0, 32'h0000_0104, 0, 0, 0, 32'h3002));
        vq.push_back(mk(1, 1, 1, 32'hFFFF_FFFC, 0, 0, 32'h0000_0104, 0, 0, 0, 32'h3002));
        vq.push_back(mk(0, 1, 0, 32'h0,        0,  1, 32'hFFFF_FFFC, 1, 0, 0, 32'h3002));
        vq.push_back(mk(0, 0, 0, 32'h0,        0,  1, 32'h0000_0000, 1, 0, 0, 32'h3002));
        vq.push_back(mk(0, 0, 0, 32'h0,        1,  1, 32'h0000_0000, 1, 0, 0, 32'h3002));
        vq.push_back(mk(0, 1, 0, 32'h0,        0,  1, 32'h0000_0000, 1, 0, 0, 32'h3002));
        vq.push_back(mk(1, 1, 1, 32'h0000_6000, 1, 0, 32'h0000_0004, 1, 0, 0, 32'h3002));
        vq.push_back(mk(1, 1, 0, 32'h0,        1,  0, 32'h0000_6000, 0, 0, 0, 32'h3002));
        vq.push_back(mk(0, 1, 1, 32'h0000_7002, 0, 0, 32'h0000_6000, 0, 0, 1, 32'h3002));
        vq.push_back(mk(0, 1, 0, 32'h0,        0,  0, 32'h0000_6000, 0, 0, 1, 32'h3002));

        @(negedge clk);
        #1;
        chk_reset("reset");

        @(negedge clk);
        rst_n = 1'b1;
        foreach (vq[i]) begin
            string tag;
            if (i > 0) @(negedge clk);
            tag            = $sformatf("row%0d", i);
            stall          = vq[i].stall;
            imem_req_ready = vq[i].rdy;
            redirect_valid = vq[i].rv;
            redirect_pc    = vq[i].rpc;
            halt           = vq[i].hlt;
            if (vq[i].v && vq[i].rdy) sb.push_back({vq[i].addr, vq[i].ep});
            #1;
            chk({tag, "_valid"},  33'(imem_req_valid), 33'(vq[i].v));
            chk({tag, "_addr"},   33'(imem_req_addr),  33'(vq[i].addr));
            chk({tag, "_epoch"},  33'(imem_req_epoch), 33'(vq[i].ep));
            chk({tag, "_mis"},    33'(misalign_err),   33'(vq[i].me));
            chk({tag, "_halted"}, 33'(halted),         33'(vq[i].hd));
            chk({tag, "_badpc"},  33'(bad_pc),         33'(vq[i].bad));
            if (imem_req_valid && imem_req_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s_sb_unexpected actual=%h required=none", tag,
                             {imem_req_addr, imem_req_epoch});
                end else begin
                    chk({tag, "_sb"}, {imem_req_addr, imem_req_epoch}, sb.pop_front());
                end
            end
        end

        // Reset out of HALTED, then drop an in-flight request with an async reset.
        @(negedge clk);
        stall = 1'b0; halt = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_halted");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("boot_valid", 33'(imem_req_valid), 33'(1'b0));
        @(negedge clk);
        #1;
        chk("fetch_valid", 33'(imem_req_valid), 33'(1'b1));
        chk("fetch_addr",  33'(imem_req_addr),  33'(32'h0000_2000));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreq_valid", 33'(imem_req_valid), 33'(1'b0));
        chk("midreq_addr",  33'(imem_req_addr),  33'(32'h0000_2000));
        @(negedge clk);
        rst_n = 1'b1;

        chk("sb_drain", 33'(sb.size()), 33'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
